// File: rtl/fp_normalizer.sv
// ---------------------------------------------------------------------------
// fp_normalizer
// Post-add normalizer for a small floating-point format: 4-bit exponent,
// 8-bit fraction with an explicit leading one in bit 7. Takes the raw 9-bit
// fraction sum from the align/add stage and produces a normalized result.
// A carry-out is handled by a right shift. Leading zeros are removed by a
// multi-cycle left-shift loop. The block also flags overflow, underflow and
// zero results.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   in_valid / in_ready   upstream handshake; raw sum sampled on transfer
//   sign_in, exp_in       sign and exponent of the raw sum
//   sum_in[8:0]           raw fraction sum, bit 8 = carry-out
//   out_valid / out_ready downstream handshake; outputs hold while stalled
//   sign_out, exp_out     normalized sign and exponent
//   frac_out[7:0]         normalized fraction
//   overflow, underflow, zero  result flags (at most one set)
// ---------------------------------------------------------------------------
module fp_normalizer (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       sign_in,
    input  logic [3:0] exp_in,
    input  logic [8:0] sum_in,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       sign_out,
    output logic [3:0] exp_out,
    output logic [7:0] frac_out,
    output logic       overflow,
    output logic       underflow,
    output logic       zero
);

    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;

    state_t     state_q, state_d;
    logic [7:0] work_frac;
    logic [3:0] work_exp;
    logic       accept;
    logic       needs_shift;
    logic [7:0] frac_shl;
    logic [3:0] exp_dec;

    // Carry-out renormalization: right shift by one (LSB dropped). At the
    // top exponent it saturates to the largest representable value.
    // Result packing: {overflow, exp[3:0], frac[7:0]}.
    function automatic logic [12:0] carry_norm(input logic [3:0] e,
                                               input logic [8:0] s);
        if (e == 4'd15)
            carry_norm = {1'b1, 4'd15, 8'hFF};
        else
            carry_norm = {1'b0, e + 4'd1, s[8:1]};
    endfunction

    assign accept      = in_valid && in_ready;
    assign needs_shift = (sum_in != 9'd0) && (sum_in < 9'd128) && (exp_in != 4'd0);
    assign frac_shl    = {work_frac[6:0], 1'b0};
    assign exp_dec     = work_exp - 4'd1;

    // State register
    always_ff @(posedge clk) begin
        if (reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = needs_shift ? SHIFT : DONE;
            SHIFT:   if (frac_shl[7] || (exp_dec == 4'd0)) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs; in_ready is masked by reset so that nothing is
    // offered upstream during the reset cycle itself.
    always_comb begin
        in_ready  = (state_q == IDLE) && !reset;
        out_valid = (state_q == DONE);
    end

    // Datapath and result registers
    always_ff @(posedge clk) begin
        if (reset) begin
            work_frac <= 8'd0;
            work_exp  <= 4'd0;
            sign_out  <= 1'b0;
            exp_out   <= 4'd0;
            frac_out  <= 8'd0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            zero      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        sign_out  <= sign_in;
                        overflow  <= 1'b0;
                        underflow <= 1'b0;
                        zero      <= 1'b0;
                        work_frac <= sum_in[7:0];
                        work_exp  <= exp_in;
                        if (sum_in == 9'd0) begin
                            sign_out <= 1'b0;
                            exp_out  <= 4'd0;
                            frac_out <= 8'd0;
                            zero     <= 1'b1;
                        end else if (sum_in[8]) begin
                            {overflow, exp_out, frac_out} <= carry_norm(exp_in, sum_in);
                        end else if (sum_in[7]) begin
                            exp_out  <= exp_in;
                            frac_out <= sum_in[7:0];
                        end else if (exp_in == 4'd0) begin
                            exp_out   <= 4'd0;
                            frac_out  <= sum_in[7:0];
                            underflow <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    work_frac <= frac_shl;
                    work_exp  <= exp_dec;
                    // Leading one found takes priority over hitting exponent 0.
                    if (frac_shl[7]) begin
                        exp_out  <= exp_dec;
                        frac_out <= frac_shl;
                    end else if (exp_dec == 4'd0) begin
                        exp_out   <= 4'd0;
                        frac_out  <= frac_shl;
                        underflow <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        overflow  <= 1'b0;
                        underflow <= 1'b0;
                        zero      <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_normalizer.sv
module tb_fp_normalizer;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic       sign_in;
    logic [3:0] exp_in;
    logic [8:0] sum_in;
    logic       out_valid;
    logic       out_ready;
    logic       sign_out;
    logic [3:0] exp_out;
    logic [7:0] frac_out;
    logic       overflow;
    logic       underflow;
    logic       zero;

    int n_checks = 0;
    int n_pass   = 0;

    fp_normalizer dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sign_in   (sign_in),
        .exp_in    (exp_in),
        .sum_in    (sum_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sign_out  (sign_out),
        .exp_out   (exp_out),
        .frac_out  (frac_out),
        .overflow  (overflow),
        .underflow (underflow),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        int s;
        int e;
        int f;
        int ov;
        int uf;
        int z;
        int shifts;
    } res_t;

    // Reference: normalize by arithmetic on integers, counting the
    // one-per-cycle left shifts needed.
    function automatic res_t model(input int s, input int e, input int sum);
        res_t r;
        r.s = s; r.e = e; r.f = 0; r.ov = 0; r.uf = 0; r.z = 0; r.shifts = 0;
        if (sum == 0) begin
            r.s = 0; r.e = 0; r.f = 0; r.z = 1;
        end else if (sum >= 256) begin
            if (e < 15) begin
                r.e = e + 1; r.f = sum / 2;
            end else begin
                r.e = 15; r.f = 255; r.ov = 1;
            end
        end else if (sum >= 128) begin
            r.f = sum;
        end else if (e == 0) begin
            r.f = sum; r.uf = 1;
        end else begin
            r.f = sum;
            do begin
                r.f = (r.f * 2) % 256;
                r.e = r.e - 1;
                r.shifts++;
            end while (r.f < 128 && r.e > 0);
            r.uf = (r.f < 128) ? 1 : 0;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input int obs, input int expv);
        n_checks++;
        assert (obs === expv) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic chk_result(input string tag, input res_t r);
        chk({tag, ".sign"}, int'(sign_out), r.s);
        chk({tag, ".exp"},  int'(exp_out),  r.e);
        chk({tag, ".frac"}, int'(frac_out), r.f);
        chk({tag, ".ovf"},  int'(overflow), r.ov);
        chk({tag, ".udf"},  int'(underflow), r.uf);
        chk({tag, ".zero"}, int'(zero),     r.z);
    endtask

    // Offer one raw sum, wait for the result, stall it, then release it.
    task automatic run_txn(input string tag, input int s, input int e,
                           input int sum, input int stall);
        res_t r;
        int   lat;
        int   waited;
        r = model(s, e, sum);
        waited = 0;
        while (!in_ready && waited < 20) begin
            @(posedge clk); #1; waited++;
        end
        chk({tag, ".in_ready"}, int'(in_ready), 1);
        sign_in  = s[0];
        exp_in   = e[3:0];
        sum_in   = sum[8:0];
        in_valid = 1'b1;
        out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        sign_in  = ~sign_in;
        sum_in   = 9'h155;
        exp_in   = 4'hA;
        lat = 1;
        while (!out_valid && lat < 20) begin
            chk({tag, ".busy_in_ready"}, int'(in_ready), 0);
            @(posedge clk); #1; lat++;
        end
        chk({tag, ".latency"}, lat, 1 + r.shifts);
        chk_result(tag, r);
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            chk({tag, ".stall_valid"}, int'(out_valid), 1);
            chk({tag, ".stall_in_ready"}, int'(in_ready), 0);
            chk_result({tag, ".stall"}, r);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, ".released"}, int'(out_valid), 0);
        chk({tag, ".idle_in_ready"}, int'(in_ready), 1);
        chk({tag, ".flags_clear"}, int'(overflow | underflow | zero), 0);
    endtask

    initial begin
        res_t r;
        int   cat;
        int   rs, re, rsum;
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        sign_in   = 1'b0;
        exp_in    = 4'd0;
        sum_in    = 9'd0;
        @(posedge clk); #1;
        chk("reset.in_ready", int'(in_ready), 0);
        @(posedge clk); #1;
        chk("reset.out_valid", int'(out_valid), 0);
        r = model(0, 0, 0);
        r.z = 0;
        chk_result("reset", r);
        reset = 1'b0;
        #1;
        chk("reset.release_in_ready", int'(in_ready), 1);

        // Directed cases
        run_txn("carry",     1, 5,  'h120, 0);
        run_txn("shift2",    0, 5,  'h020, 0);
        run_txn("udf_shift", 1, 3,  'h001, 0);
        run_txn("ovf",       0, 15, 'h1FF, 0);
        run_txn("zero",      1, 9,  'h000, 0);
        run_txn("normal",    1, 7,  'h0A5, 0);
        run_txn("udf_exp0",  0, 0,  'h033, 0);
        run_txn("lead_e1",   1, 1,  'h040, 0);
        run_txn("max_shift", 0, 12, 'h001, 0);
        run_txn("stall5",    1, 4,  'h130, 5);

        // Reset during SHIFT discards the in-flight result
        sign_in = 1'b1; exp_in = 4'd7; sum_in = 9'h002; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        chk("rst_shift.in_ready_low", int'(in_ready), 0);
        @(posedge clk); #1;
        chk("rst_shift.out_valid", int'(out_valid), 0);
        r = model(0, 0, 0);
        r.z = 0;
        chk_result("rst_shift", r);
        reset = 1'b0;
        #1;
        chk("rst_shift.in_ready", int'(in_ready), 1);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            chk("rst_shift.no_valid", int'(out_valid), 0);
        end

        // Randomized traffic across all result categories
        for (int t = 0; t < 40; t++) begin
            cat = $urandom_range(0, 4);
            rs  = $urandom_range(0, 1);
            re  = $urandom_range(0, 15);
            case (cat)
                0: rsum = 0;
                1: rsum = $urandom_range(256, 511);
                2: rsum = $urandom_range(128, 255);
                default: rsum = $urandom_range(1, 127);
            endcase
            run_txn("rand", rs, re, rsum, $urandom_range(0, 2));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
